// File: rtl/clock_period_meter.sv
// Measures period and high-time of a slow signal in clock_in cycles,
// with a per-period valid strobe and a no-edge timeout.
module clock_period_meter #(
    parameter int unsigned          CNT_W   = 28,
    parameter logic [CNT_W-1:0]     TIMEOUT = 28'd200000000
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             sync1, s, s_d;
    logic             rise;
    logic [CNT_W-1:0] pcnt, pcnt_nxt;
    logic [CNT_W-1:0] hcnt, hcnt_nxt;
    logic [CNT_W-1:0] period_nxt, high_nxt;
    logic             valid_nxt, timeout_nxt;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= sig_in;
            s     <= sync1;
            s_d   <= s;
        end
    end

    assign rise = s & ~s_d;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pcnt       <= '0;
            hcnt       <= '0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pcnt       <= pcnt_nxt;
            hcnt       <= hcnt_nxt;
            period_out <= period_nxt;
            high_out   <= high_nxt;
            valid      <= valid_nxt;
            timeout    <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pcnt_nxt    = pcnt;
        hcnt_nxt    = hcnt;
        period_nxt  = period_out;
        high_nxt    = high_out;
        valid_nxt   = 1'b0;
        timeout_nxt = timeout;

        if (!enable) begin
            state_nxt   = IDLE;
            pcnt_nxt    = '0;
            hcnt_nxt    = '0;
            timeout_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    pcnt_nxt    = '0;
                    hcnt_nxt    = '0;
                    timeout_nxt = 1'b0;
                    state_nxt   = ARM;
                end
                ARM: begin
                    if (rise) begin
                        pcnt_nxt  = CNT_W'(1);
                        hcnt_nxt  = CNT_W'(1);
                        state_nxt = MEASURE;
                    end else if (!timeout) begin
                        // once timed out, the counter stays frozen until a fresh edge arms
                        if (pcnt == TIMEOUT) begin
                            timeout_nxt = 1'b1;
                            period_nxt  = '0;
                            high_nxt    = '0;
                        end else begin
                            pcnt_nxt = pcnt + CNT_W'(1);
                        end
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_nxt  = pcnt;
                        high_nxt    = hcnt;
                        valid_nxt   = 1'b1;
                        timeout_nxt = 1'b0;
                        pcnt_nxt    = CNT_W'(1);
                        hcnt_nxt    = CNT_W'(1);
                    end else if (pcnt == TIMEOUT) begin
                        timeout_nxt = 1'b1;
                        period_nxt  = '0;
                        high_nxt    = '0;
                        pcnt_nxt    = '0;
                        hcnt_nxt    = '0;
                        state_nxt   = ARM;
                    end else begin
                        pcnt_nxt = pcnt + CNT_W'(1);
                        hcnt_nxt = hcnt + CNT_W'(s);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: expected period/high pairs are queued
// as each sig_in rise is driven and retired when valid pulses.
module tb_clock_period_meter;

    localparam int unsigned      CNT_W   = 28;
    localparam logic [CNT_W-1:0] TIMEOUT = 28'd50;

    logic             clock_in = 1'b0;
    logic             reset_n  = 1'b0;
    logic             sig_in   = 1'b0;
    logic             enable   = 1'b0;
    logic [CNT_W-1:0] period_out, high_out;
    logic             valid, timeout;

    int               vectors    = 0;
    int               miscompares = 0;
    logic [2*CNT_W-1:0] exp_q[$];
    logic             have_ref = 1'b0;
    int unsigned      prev_h = 0, prev_l = 0;
    logic             prev_valid = 1'b0;

    clock_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .enable     (enable),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .timeout    (timeout)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    // Rise-to-rise distance equals the previous period's high+low.
    task automatic drive_rise(input int unsigned h, input int unsigned l);
        sig_in = 1'b1;
        if (enable) begin
            if (have_ref) exp_q.push_back({CNT_W'(prev_h + prev_l), CNT_W'(prev_h)});
            have_ref = 1'b1;
        end else begin
            have_ref = 1'b0;
        end
        prev_h = h;
        prev_l = l;
    endtask

    task automatic run(input int unsigned h, input int unsigned l, input int n);
        for (int i = 0; i < n; i++) begin
            drive_rise(h, l);
            cyc(h);
            sig_in = 1'b0;
            cyc(l);
        end
    endtask

    always @(negedge clock_in) begin
        if (reset_n) begin
            if (valid) begin
                logic [2*CNT_W-1:0] e;
                check("valid_back_to_back", 64'(prev_valid), 64'd0);
                check("valid_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("period_out", 64'(period_out), 64'(e[2*CNT_W-1:CNT_W]));
                    check("high_out", 64'(high_out), 64'(e[CNT_W-1:0]));
                    check("timeout_on_valid", 64'(timeout), 64'd0);
                end
            end
            prev_valid = valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #2;
        check("rst_period", 64'(period_out), 64'd0);
        check("rst_high", 64'(high_out), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        cyc(3);
        reset_n = 1'b1;
        cyc(2);
        enable = 1'b1;

        // divider, asymmetric, fastest input
        run(5, 5, 6);
        run(3, 4, 5);
        run(1, 1, 6);
        run(5, 5, 3);

        // timeout: last rise then constant low
        drive_rise(5, 5);
        cyc(5);
        sig_in = 1'b0;
        cyc(47);
        check("timeout_early", 64'(timeout), 64'd0);
        cyc(1);
        check("timeout_set", 64'(timeout), 64'd1);
        check("timeout_period", 64'(period_out), 64'd0);
        check("timeout_high", 64'(high_out), 64'd0);
        have_ref = 1'b0;
        cyc(10);
        check("timeout_held", 64'(timeout), 64'd1);
        run(5, 5, 3);
        check("timeout_cleared", 64'(timeout), 64'd0);

        // enable dropped 4 cycles after a rise, low for 20 cycles
        drive_rise(5, 5);
        cyc(4);
        enable   = 1'b0;
        have_ref = 1'b0;
        cyc(1);
        sig_in = 1'b0;
        cyc(5);
        run(5, 5, 1);
        drive_rise(5, 5);
        cyc(4);
        enable = 1'b1;
        check("en_hold_period", 64'(period_out), 64'd10);
        check("en_hold_high", 64'(high_out), 64'd5);
        check("en_timeout", 64'(timeout), 64'd0);
        cyc(1);
        sig_in = 1'b0;
        cyc(5);
        run(5, 5, 3);

        // period change 10 -> 16
        run(8, 8, 3);
        run(5, 5, 2);

        // async reset in the low phase, unaligned to the clock
        drive_rise(5, 5);
        cyc(5);
        sig_in = 1'b0;
        #3 reset_n = 1'b0;
        have_ref = 1'b0;
        #2;
        check("arst_period", 64'(period_out), 64'd0);
        check("arst_high", 64'(high_out), 64'd0);
        check("arst_valid", 64'(valid), 64'd0);
        check("arst_timeout", 64'(timeout), 64'd0);
        @(negedge clock_in);
        cyc(1);
        #4 reset_n = 1'b1;
        @(negedge clock_in);
        cyc(2);
        run(5, 5, 3);
        drive_rise(5, 5);
        cyc(6);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
